mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access sequencer for an in-order pipeline.
// A load/store in EX/MEM is latched in IDLE, driven to the data memory in ACCESS
// until dm_ack, then released for one DONE cycle so the instruction retires once.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   mem_read, mem_write   MEM-stage op type (both high = store)
//   address, wr_data      MEM-stage effective address and store data
//   dm_req/dm_we          memory request (held until ack) and its write qualifier
//   dm_addr/dm_wdata      latched request address and store data
//   dm_ack, dm_rdata      memory completion and same-cycle read data
//   stall                 freezes PC, IF/ID, ID/EX and EX/MEM
//   wb_bubble             forces RegWrite=0/MemToReg=0 into MEM/WB
//   load_data             captured load result for MEM/WB
//   err                   one-cycle timeout pulse (DONE cycle)
//
// Optional feature: define MEMCTRL_TIMEOUT_EN to abort an ACCESS after
// TIMEOUT_CYCLES cycles without dm_ack. Without it err is tied low and ACCESS
// waits indefinitely.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [63:0] address,
  input  logic [63:0] wr_data,
  output logic        dm_req,
  output logic        dm_we,
  output logic [63:0] dm_addr,
  output logic [63:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [63:0] dm_rdata,
  output logic        stall,
  output logic        wb_bubble,
  output logic [63:0] load_data,
  output logic        err
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] load_q, load_d;
  logic        timeout;  // ACCESS cycle that hits the limit with no ack

  logic mem_op;
  assign mem_op = mem_read | mem_write;

`ifdef MEMCTRL_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  // Count is zero whenever ACCESS is entered, since it is held clear outside ACCESS.
  always_comb begin
    cnt_d = '0;
    if (state_q == StAccess && !dm_ack) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Ack in the limit cycle wins over the abort.
  assign timeout = (state_q == StAccess) && !dm_ack && (cnt_q == CntLast);
  assign err_d   = timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign err                = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (mem_op) state_d = StAccess;
      StAccess: if (dm_ack || timeout) state_d = StDone;
      StDone:   state_d = StIdle;  // op still in EX/MEM here; must not restart
      default:  state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    dm_req = (state_q == StAccess);
    stall  = 1'b0;
    if (!reset) begin
      case (state_q)
        StIdle:   stall = mem_op;
        StAccess: stall = 1'b1;
        default:  stall = 1'b0;
      endcase
    end
    wb_bubble = stall;
  end

  // Request and load-result datapath
  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    if (state_q == StIdle && mem_op) begin
      we_d    = mem_write;
      addr_d  = address;
      wdata_d = wr_data;
    end
    if (state_q == StAccess) begin
      if (dm_ack) begin
        if (!we_q) load_d = dm_rdata;
      end else if (timeout) begin
        load_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
    end
  end

  assign dm_we     = we_q;
  assign dm_addr   = addr_q;
  assign dm_wdata  = wdata_q;
  assign load_data = load_q;

endmodule
